// File: rtl/cube_root_checker_if.sv
// ============================================================================
// Module      : cube_root_checker_if
// Description : Request/result bundle between a requester and the cube-root
//               checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cube_root_checker_if;
    logic        start;
    logic [31:0] in;
    logic [10:0] root;
    logic        busy;
    logic        done;
    logic [33:0] cube;
    logic [31:0] remainder;
    logic        over;
    logic        ok;

    modport master (
        output start, in, root,
        input  busy, done, cube, remainder, over, ok
    );

    modport slave (
        input  start, in, root,
        output busy, done, cube, remainder, over, ok
    );
endinterface

`default_nettype wire

// File: rtl/cube_root_checker.sv
// ============================================================================
// Module      : cube_root_checker
// Description : Verifies that a candidate root is the exact floor cube root
//               of a 32-bit radicand using two serial shift-add multiplies.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cube_root_checker (
    input  wire logic          clock,
    input  wire logic          clear,
    cube_root_checker_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SQUARE = 3'd1,
        S_CUBE   = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] C_LAST_BIT = 4'd10;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_busy;
    logic        w_done;

    logic [31:0] r_in;
    logic [10:0] r_root;
    logic [21:0] r_sq;
    logic [33:0] r_acc;
    logic [3:0]  r_cnt;

    logic [33:0] r_cube;
    logic [31:0] r_rem;
    logic        r_over;
    logic        r_ok;

    logic [21:0] w_sq_add;
    logic [33:0] w_cube_add;
    logic [33:0] w_sq34;
    logic [33:0] w_root34;
    logic [33:0] w_in34;
    logic [33:0] w_next;
    logic        w_over;
    logic [31:0] w_rem;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = (r_state != S_IDLE);
        w_done       = (r_state == S_DONE);
        case (r_state)
            S_IDLE:   if (bus.start) w_state_next = S_SQUARE;
            S_SQUARE: if (r_cnt == C_LAST_BIT) w_state_next = S_CUBE;
            S_CUBE:   if (r_cnt == C_LAST_BIT) w_state_next = S_CHECK;
            S_CHECK:  w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // One multiplier bit per cycle, LSB first; the root supplies the multiplier bits in both passes.
    always_comb begin
        w_sq_add   = r_root[r_cnt] ? ({11'd0, r_root} << r_cnt) : 22'd0;
        w_cube_add = r_root[r_cnt] ? ({12'd0, r_sq} << r_cnt) : 34'd0;
        w_sq34     = {12'd0, r_sq};
        w_root34   = {23'd0, r_root};
        w_in34     = {2'd0, r_in};
        w_next     = r_acc + w_sq34 + (w_sq34 << 1) + w_root34 + (w_root34 << 1) + 34'd1;
        w_over     = (r_acc > w_in34);
        // When the cube does not exceed the radicand it fits in 32 bits, so a 32-bit subtract is exact.
        w_rem      = r_in - r_acc[31:0];
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_in   <= 32'd0;
            r_root <= 11'd0;
            r_sq   <= 22'd0;
            r_acc  <= 34'd0;
            r_cnt  <= 4'd0;
            r_cube <= 34'd0;
            r_rem  <= 32'd0;
            r_over <= 1'b0;
            r_ok   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_in   <= bus.in;
                        r_root <= bus.root;
                        r_sq   <= 22'd0;
                        r_acc  <= 34'd0;
                        r_cnt  <= 4'd0;
                    end
                end
                S_SQUARE: begin
                    r_sq  <= r_sq + w_sq_add;
                    r_cnt <= (r_cnt == C_LAST_BIT) ? 4'd0 : r_cnt + 4'd1;
                end
                S_CUBE: begin
                    r_acc <= r_acc + w_cube_add;
                    r_cnt <= (r_cnt == C_LAST_BIT) ? 4'd0 : r_cnt + 4'd1;
                end
                S_CHECK: begin
                    r_cube <= r_acc;
                    r_over <= w_over;
                    r_ok   <= !w_over && (w_in34 < w_next);
                    r_rem  <= w_over ? 32'd0 : w_rem;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.cube      = r_cube;
    assign bus.remainder = r_rem;
    assign bus.over      = r_over;
    assign bus.ok        = r_ok;

endmodule

`default_nettype wire

// File: tb/tb_cube_root_checker.sv
// ============================================================================
// Module      : tb_cube_root_checker
// Description : Self-checking bench for cube_root_checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cube_root_checker;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   done_cnt;

    cube_root_checker_if bus ();

    cube_root_checker dut (
        .clock (clk),
        .clear (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [31:0] a;
        logic [10:0] r;
        logic [33:0] cube;
        logic [31:0] rem;
        logic        over;
        logic        ok;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: floor-cube-root relation from plain 64-bit arithmetic.
    function automatic void model(input logic [31:0] a, input logic [10:0] r,
                                  output logic [33:0] c, output logic [31:0] rem,
                                  output logic ov, output logic ok);
        longint unsigned lr, lc, ln, la;
        lr  = longint'(r);
        la  = longint'(a);
        lc  = lr * lr * lr;
        ln  = (lr + 1) * (lr + 1) * (lr + 1);
        c   = lc[33:0];
        ov  = (lc > la);
        rem = ov ? 32'd0 : 32'(la - lc);
        ok  = (lc <= la) && (la < ln);
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [10:0] r, output int lat);
        @(posedge clk); #1;
        bus.in    = a;
        bus.root  = r;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] a, input logic [10:0] r,
                                input logic [33:0] c, input logic [31:0] rem,
                                input logic ov, input logic ok, input int lat);
        check({tag, " latency"},   64'(lat), 64'd23);
        check({tag, " cube"},      64'(bus.cube), 64'(c));
        check({tag, " remainder"}, 64'(bus.remainder), 64'(rem));
        check({tag, " over"},      64'(bus.over), 64'(ov));
        check({tag, " ok"},        64'(bus.ok), 64'(ok));
        if (bus.cube !== c) $display("  operands in=%0d root=%0d", a, r);
    endtask

    initial begin
        int          lat;
        int          d0;
        int          n;
        logic [33:0] mc;
        logic [31:0] mr;
        logic        mo;
        logic        mk;
        logic [31:0] ra;
        logic [10:0] rr;
        longint unsigned lc;

        checks    = 0;
        errors    = 0;
        done_cnt  = 0;
        bus.start = 1'b0;
        bus.in    = 32'd0;
        bus.root  = 11'd0;

        vecs[0] = '{32'd8120601,    11'd201,  34'd8120601,    32'd0,       1'b0, 1'b1};
        vecs[1] = '{32'd8120601,    11'd200,  34'd8000000,    32'd120601,  1'b0, 1'b0};
        vecs[2] = '{32'd8120600,    11'd201,  34'd8120601,    32'd0,       1'b1, 1'b0};
        vecs[3] = '{32'hFFFFFFFF,   11'd1625, 34'd4291015625, 32'd3951670, 1'b0, 1'b1};
        vecs[4] = '{32'hFFFFFFFF,   11'd2047, 34'd8577357823, 32'd0,       1'b1, 1'b0};
        vecs[5] = '{32'd0,          11'd0,    34'd0,          32'd0,       1'b0, 1'b1};
        vecs[6] = '{32'd7,          11'd1,    34'd1,          32'd6,       1'b0, 1'b1};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset cube", 64'(bus.cube), 64'd0);
        check("reset remainder", 64'(bus.remainder), 64'd0);
        check("reset over/ok", 64'({bus.over, bus.ok}), 64'd0);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].r, lat);
            check_result($sformatf("vec%0d", i), vecs[i].a, vecs[i].r, vecs[i].cube,
                         vecs[i].rem, vecs[i].over, vecs[i].ok, lat);
        end

        // Random operands: half chosen near a true cube so ok/over boundaries are exercised.
        for (int i = 0; i < 24; i++) begin
            rr = 11'($urandom_range(0, 2047));
            lc = longint'(rr) * longint'(rr) * longint'(rr);
            if (i % 2 == 0 || lc > 64'hFFFF_FFFE) ra = $urandom;
            else ra = 32'(lc + 64'($urandom_range(0, 2)) - ((lc > 0) ? 64'd1 : 64'd0));
            model(ra, rr, mc, mr, mo, mk);
            run_op(ra, rr, lat);
            check_result($sformatf("rand%0d", i), ra, rr, mc, mr, mo, mk, lat);
        end

        // start re-pulsed with different operands while busy must be ignored.
        @(posedge clk); #1;
        d0 = done_cnt;
        bus.in = 32'd0; bus.root = 11'd0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i == 4 || i == 11 || i == 19) begin
                bus.start = 1'b1; bus.in = 32'd5; bus.root = 11'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("repulse done count", 64'(done_cnt - d0), 64'd1);
        check("repulse cube", 64'(bus.cube), 64'd0);
        check("repulse ok", 64'(bus.ok), 64'd1);

        // Leave non-zero outputs behind, then abort a request during CUBE.
        run_op(32'd1000, 11'd9, lat);
        check("preclear cube", 64'(bus.cube), 64'd729);
        @(posedge clk); #1;
        bus.in = 32'd5000; bus.root = 11'd17; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        d0  = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("clear busy", 64'(bus.busy), 64'd0);
        check("clear done", 64'(bus.done), 64'd0);
        check("clear cube", 64'(bus.cube), 64'd0);
        check("clear remainder", 64'(bus.remainder), 64'd0);
        check("clear over/ok", 64'({bus.over, bus.ok}), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("clear no done", 64'(done_cnt - d0), 64'd0);
        run_op(32'd5000, 11'd17, lat);
        model(32'd5000, 11'd17, mc, mr, mo, mk);
        check_result("after clear", 32'd5000, 11'd17, mc, mr, mo, mk, lat);

        // clear wins over start at the same edge.
        @(posedge clk); #1;
        bus.start = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; rst = 1'b0;
        check("clear priority busy", 64'(bus.busy), 64'd0);

        // start held high: one result every 25 cycles.
        bus.in = 32'd64; bus.root = 11'd4; bus.start = 1'b1;
        n = 0;
        while (!bus.done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b first done seen", 64'(bus.done), 64'd1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.done && n < 100);
        bus.start = 1'b0;
        check("b2b period", 64'(n), 64'd25);
        check("b2b cube", 64'(bus.cube), 64'd64);
        check("b2b ok", 64'(bus.ok), 64'd1);
        repeat (30) @(posedge clk);
        #1;
        check("b2b idle", 64'(bus.busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cube_root_checker.md
CUBE_ROOT_CHECKER -- requirements
Module: cube_root_checker

Interface
REQ-001 The block SHALL have exactly one clock and one reset, and the reset SHALL be synchronous and active-high.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 clear  input  1  synchronous active-high reset.
REQ-004 start  input  1  request to check one operand pair; sampled only in IDLE.
REQ-005 in  input  32  unsigned radicand, as presented to the upstream cube-root calculator.
REQ-006 root  input  11  unsigned candidate cube root produced by the upstream calculator.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse; result outputs are valid while high.
REQ-009 cube  output  34  root^3, full width, no truncation.
REQ-010 remainder  output  32  in - cube when cube <= in; otherwise 0.
REQ-011 over  output  1  high when cube > in.
REQ-012 ok  output  1  high when cube <= in < (root+1)^3, i.e. root is the exact floor cube root.

Function
REQ-013 The FSM SHALL have the states IDLE, SQUARE, CUBE, CHECK and DONE, encoded in one state register.
REQ-014 IDLE with start=1 SHALL latch in and root, clear the accumulator and step counter, and go to SQUARE; IDLE with start=0 SHALL stay in IDLE.
REQ-015 SQUARE SHALL compute root*root (22 bits) by shift-add at one multiplier bit per cycle, LSB first, over exactly 11 cycles, and SHALL then go to CUBE.
REQ-016 CUBE SHALL compute square*root (33 bits, held in a 34-bit register) by the same method over exactly 11 cycles, and SHALL then go to CHECK.
REQ-017 CHECK SHALL, in one cycle:
  - form next = cube + 3*square + 3*root + 1 (34 bits);
  - register cube, over, ok and remainder;
  - go to DONE.
REQ-018 DONE SHALL assert done for exactly one cycle and SHALL go to IDLE unconditionally.
REQ-019 Latency: if start is sampled at edge k, done SHALL be high in the cycle following edge k+23.
REQ-020 start asserted in any state other than IDLE SHALL be ignored; latched operands SHALL NOT change mid-operation.
REQ-021 start held high continuously SHALL launch a new operation on the first IDLE cycle after each DONE, giving one result every 25 cycles.
REQ-022 All arithmetic SHALL be unsigned with no overflow: in is compared zero-extended to 34 bits.
REQ-023 Outputs cube, remainder, over and ok SHALL hold their last registered values until the next CHECK or clear.
REQ-024 root=0 SHALL give cube=0 and next=1.

Reset
REQ-025 clear=1 at a rising edge SHALL force IDLE and zero all outputs, latched operands, the accumulator and the counter, in any state.
REQ-026 clear has priority over start when both are high at the same edge.
REQ-027 clear mid-operation SHALL abort the operation, and done SHALL NOT pulse for the aborted request.

Verification
REQ-028 in=8120601, root=201 -> cube=8120601, remainder=0, over=0, ok=1, done at edge k+23.
REQ-029 in=8120601, root=200 -> cube=8000000, remainder=120601, over=0, ok=0 (next=8120601 is not greater than in).
REQ-030 in=8120600, root=201 -> over=1, remainder=0, ok=0.
REQ-031 in=0xFFFFFFFF, root=1625 -> cube=4291015625, remainder=3951670, ok=1; root=2047 -> cube=8577357823, over=1, ok=0.
REQ-032 in=0, root=0 -> cube=0, remainder=0, ok=1; start re-pulsed while busy -> no effect, a single done.
REQ-033 clear asserted during CUBE -> IDLE at the next edge, all outputs 0, busy=0, no done pulse; a fresh start afterwards completes normally.
